mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 156 +++++++++++++++
 tb/tb_mux_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// Two-port burst arbiter that pops show-ahead FIFOs and registers the muxed word.
// Optional per-port pop statistics are enabled by defining MUX_ARBITER_STATS_EN.
module mux_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic [7:0] data_in_0,
    input  logic [7:0] data_in_1,
    input  logic       pause,
    output logic       pop_0,
    output logic       pop_1,
    output logic       sel,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [7:0] grant_cnt_0,
    output logic [7:0] grant_cnt_1
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

    state_t     state_q;
    logic [3:0] burstCnt_q;
    logic [3:0] burstCnt_d;
    logic       lastGrant_q;
    logic       sel_q;
    logic [7:0] data_q;
    logic       valid_q;

    logic       req0;
    logic       req1;
    logic       popAny;
    logic [7:0] popData;

    assign req0       = !fifo_empty_0;
    assign req1       = !fifo_empty_1;
    assign pop_0      = (state_q == GRANT0) && req0 && !pause;
    assign pop_1      = (state_q == GRANT1) && req1 && !pause;
    assign popAny     = pop_0 || pop_1;
    assign popData    = pop_1 ? data_in_1 : data_in_0;
    assign burstCnt_d = burstCnt_q + 4'd1;

    // Pause freezes the whole arbitration decision, so a pending switch waits for it to drop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            burstCnt_q  <= 4'd0;
            lastGrant_q <= 1'b1;
            sel_q       <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= popAny;
            if (popAny) begin
                data_q <= popData;
                sel_q  <= pop_1;
            end
            if (!pause) begin
                case (state_q)
                    IDLE: begin
                        if (req0 && (!req1 || lastGrant_q)) begin
                            state_q     <= GRANT0;
                            burstCnt_q  <= 4'd0;
                            lastGrant_q <= 1'b0;
                        end else if (req1) begin
                            state_q     <= GRANT1;
                            burstCnt_q  <= 4'd0;
                            lastGrant_q <= 1'b1;
                        end
                    end
                    GRANT0: begin
                        if (!req0) begin
                            burstCnt_q <= 4'd0;
                            if (req1) begin
                                state_q     <= GRANT1;
                                lastGrant_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (burstCnt_q == LAST_BEAT) begin
                            burstCnt_q <= 4'd0;
                            if (req1) begin
                                state_q     <= GRANT1;
                                lastGrant_q <= 1'b1;
                            end
                        end else begin
                            burstCnt_q <= burstCnt_d;
                        end
                    end
                    GRANT1: begin
                        if (!req1) begin
                            burstCnt_q <= 4'd0;
                            if (req0) begin
                                state_q     <= GRANT0;
                                lastGrant_q <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (burstCnt_q == LAST_BEAT) begin
                            burstCnt_q <= 4'd0;
                            if (req0) begin
                                state_q     <= GRANT0;
                                lastGrant_q <= 1'b0;
                            end
                        end else begin
                            burstCnt_q <= burstCnt_d;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        burstCnt_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign sel       = sel_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;

`ifdef MUX_ARBITER_STATS_EN
    logic [7:0] grantCnt0_q;
    logic [7:0] grantCnt1_q;

    // Free-running pop counters; they wrap naturally at 8 bits.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            grantCnt0_q <= 8'h00;
            grantCnt1_q <= 8'h00;
        end else begin
            if (pop_0) begin
                grantCnt0_q <= grantCnt0_q + 8'd1;
            end
            if (pop_1) begin
                grantCnt1_q <= grantCnt1_q + 8'd1;
            end
        end
    end

    assign grant_cnt_0 = grantCnt0_q;
    assign grant_cnt_1 = grantCnt1_q;
`else
    assign grant_cnt_0 = 8'h00;
    assign grant_cnt_1 = 8'h00;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed table, hand sequences and a
// randomized run against a queue-based reference model of the arbitration rules.
module tb_mux_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       fifo_empty_0 = 1'b1;
    logic       fifo_empty_1 = 1'b1;
    logic [7:0] data_in_0 = 8'h00;
    logic [7:0] data_in_1 = 8'h00;
    logic       pause = 1'b0;
    logic       pop_0;
    logic       pop_1;
    logic       sel;
    logic [7:0] data_out;
    logic       valid_out;
    logic [7:0] grant_cnt_0;
    logic [7:0] grant_cnt_1;

    mux_arbiter #(.BURST_LEN(BURST)) dut (
        .clk(clk),
        .reset_L(reset_L),
        .fifo_empty_0(fifo_empty_0),
        .fifo_empty_1(fifo_empty_1),
        .data_in_0(data_in_0),
        .data_in_1(data_in_1),
        .pause(pause),
        .pop_0(pop_0),
        .pop_1(pop_1),
        .sel(sel),
        .data_out(data_out),
        .valid_out(valid_out),
        .grant_cnt_0(grant_cnt_0),
        .grant_cnt_1(grant_cnt_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       e0;
        logic       e1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ps;
        logic       p0;
        logic       p1;
        logic       v;
        logic [7:0] d;
        logic       s;
    } vec_t;

    vec_t tbl[10];

    int checkCount = 0;
    int passCount = 0;

    // Reference model: owner is -1 (nobody), 0 or 1; count is pops so far in this burst.
    int         mOwner;
    int         mCount;
    int         mLast;
    logic       mSel;
    logic       mValid;
    logic [7:0] mData;
    logic [7:0] mCnt0;
    logic [7:0] mCnt1;

    logic [7:0] fifo0[$];
    logic [7:0] fifo1[$];
    int         popLog[$];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic resetModel();
        mOwner = -1;
        mCount = 0;
        mLast  = 1;
        mSel   = 1'b0;
        mValid = 1'b0;
        mData  = 8'h00;
        mCnt0  = 8'h00;
        mCnt1  = 8'h00;
    endtask

    function automatic void modelPops(input logic e0, input logic e1, input logic ps,
                                      output logic p0, output logic p1);
        p0 = (mOwner == 0) && !e0 && !ps;
        p1 = (mOwner == 1) && !e1 && !ps;
    endfunction

    task automatic grantTo(input int who);
        mOwner = who;
        mCount = 0;
        mLast  = who;
    endtask

    task automatic modelStep(input logic e0, input logic e1, input logic [7:0] d0,
                             input logic [7:0] d1, input logic ps);
        logic p0;
        logic p1;
        int   x;
        logic reqX;
        logic reqO;
        modelPops(e0, e1, ps, p0, p1);
        mValid = p0 || p1;
        if (p0) begin
            mData = d0;
            mSel  = 1'b0;
`ifdef MUX_ARBITER_STATS_EN
            mCnt0 = mCnt0 + 8'd1;
`endif
        end
        if (p1) begin
            mData = d1;
            mSel  = 1'b1;
`ifdef MUX_ARBITER_STATS_EN
            mCnt1 = mCnt1 + 8'd1;
`endif
        end
        if (!ps) begin
            if (mOwner < 0) begin
                if (!e0 && !e1) grantTo(1 - mLast);
                else if (!e0) grantTo(0);
                else if (!e1) grantTo(1);
            end else begin
                x    = mOwner;
                reqX = (x == 0) ? !e0 : !e1;
                reqO = (x == 0) ? !e1 : !e0;
                if (!reqX) begin
                    if (reqO) grantTo(1 - x);
                    else begin
                        mOwner = -1;
                        mCount = 0;
                    end
                end else begin
                    mCount++;
                    if (mCount == BURST) begin
                        if (reqO) grantTo(1 - x);
                        else mCount = 0;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic e0, input logic e1, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic ps);
        fifo_empty_0 = e0;
        fifo_empty_1 = e1;
        data_in_0    = d0;
        data_in_1    = d1;
        pause        = ps;
    endtask

    // One clock of stimulus: pops are checked before the edge, registered outputs after it.
    task automatic runCycle(input logic e0, input logic e1, input logic [7:0] d0,
                            input logic [7:0] d1, input logic ps,
                            output logic p0, output logic p1);
        applyStimulus(e0, e1, d0, d1, ps);
        #1;
        modelPops(e0, e1, ps, p0, p1);
        checkFlag("pop_0", pop_0, p0);
        checkFlag("pop_1", pop_1, p1);
        popLog.push_back(p0 ? 0 : (p1 ? 1 : 2));
        @(posedge clk);
        modelStep(e0, e1, d0, d1, ps);
        @(negedge clk);
        checkFlag("valid_out", valid_out, mValid);
        checkFlag("sel", sel, mSel);
        checkOutput("data_out", data_out, mData);
        checkOutput("grant_cnt_0", grant_cnt_0, mCnt0);
        checkOutput("grant_cnt_1", grant_cnt_1, mCnt1);
    endtask

    task automatic fifoCycle(input logic ps);
        logic       e0;
        logic       e1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       p0;
        logic       p1;
        e0 = (fifo0.size() == 0);
        e1 = (fifo1.size() == 0);
        d0 = e0 ? 8'($urandom) : fifo0[0];
        d1 = e1 ? 8'($urandom) : fifo1[0];
        runCycle(e0, e1, d0, d1, ps, p0, p1);
        if (p0) void'(fifo0.pop_front());
        if (p1) void'(fifo1.pop_front());
    endtask

    task automatic checkLog(input string name, input int exp[$]);
        checkOutput({name, " length"}, 8'(popLog.size()), 8'(exp.size()));
        for (int i = 0; i < exp.size() && i < popLog.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", name, i), 8'(popLog[i]), 8'(exp[i]));
        end
    endtask

    task automatic applyReset();
        reset_L = 1'b0;
        resetModel();
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h77, 8'h88, 1'b0);
        #1;
        checkFlag("reset pop_0", pop_0, 1'b0);
        checkFlag("reset pop_1", pop_1, 1'b0);
        @(negedge clk);
        checkFlag("reset valid_out", valid_out, 1'b0);
        checkFlag("reset sel", sel, 1'b0);
        checkOutput("reset data_out", data_out, 8'h00);
        checkOutput("reset grant_cnt_0", grant_cnt_0, 8'h00);
        checkOutput("reset grant_cnt_1", grant_cnt_1, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        reset_L = 1'b1;
        popLog.delete();
    endtask

    initial begin
        logic p0;
        logic p1;
        int   exp[$];

        // Port 0 alone streams A0..A5 with one paused cycle; port 1 data must never leak through.
        tbl[0] = '{1'b0, 1'b1, 8'hA0, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'hA0, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hA1, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'hA2, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'hA3, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA2, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'hA3, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'hA4, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'hA5, 8'h5C, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 8'h5A, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};

        $display("[TB] reset release with both FIFOs empty");
        applyReset();
        repeat (3) runCycle(1'b1, 1'b1, 8'h00, 8'h00, 1'b0, p0, p1);

        $display("[TB] directed table");
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].e0, tbl[i].e1, tbl[i].d0, tbl[i].d1, tbl[i].ps);
            #1;
            checkFlag($sformatf("tbl[%0d] pop_0", i), pop_0, tbl[i].p0);
            checkFlag($sformatf("tbl[%0d] pop_1", i), pop_1, tbl[i].p1);
            @(posedge clk);
            @(negedge clk);
            checkFlag($sformatf("tbl[%0d] valid_out", i), valid_out, tbl[i].v);
            checkOutput($sformatf("tbl[%0d] data_out", i), data_out, tbl[i].d);
            checkFlag($sformatf("tbl[%0d] sel", i), sel, tbl[i].s);
        end

        $display("[TB] alternating bursts");
        applyReset();
        fifo0.delete();
        fifo1.delete();
        for (int i = 0; i < 8; i++) begin
            fifo0.push_back(8'(8'h10 + i));
            fifo1.push_back(8'(8'h20 + i));
        end
        repeat (18) fifoCycle(1'b0);
        exp.delete();
        for (int i = 0; i < 18; i++) exp.push_back((i == 0 || i > 16) ? 2 : ((i - 1) / BURST) % 2);
        checkLog("burst pattern", exp);

        $display("[TB] pause mid-burst on port 1");
        applyReset();
        fifo0.delete();
        fifo1.delete();
        for (int i = 0; i < 8; i++) begin
            fifo0.push_back(8'(8'h30 + i));
            fifo1.push_back(8'(8'h40 + i));
        end
        for (int i = 0; i < 13; i++) fifoCycle((i >= 7 && i <= 9) ? 1'b1 : 1'b0);
        exp = '{2, 0, 0, 0, 0, 1, 1, 2, 2, 2, 1, 1, 0};
        checkLog("pause pattern", exp);

        $display("[TB] port 0 runs dry mid-burst");
        applyReset();
        fifo0.delete();
        fifo1.delete();
        for (int i = 0; i < 2; i++) fifo0.push_back(8'(8'h50 + i));
        for (int i = 0; i < 4; i++) fifo1.push_back(8'(8'h60 + i));
        repeat (8) fifoCycle(1'b0);
        exp = '{2, 0, 0, 2, 1, 1, 1, 1};
        checkLog("empty handoff", exp);

        $display("[TB] asynchronous reset mid-burst");
        applyReset();
        fifo0.delete();
        fifo1.delete();
        for (int i = 0; i < 8; i++) begin
            fifo0.push_back(8'(8'h70 + i));
            fifo1.push_back(8'(8'h80 + i));
        end
        repeat (3) fifoCycle(1'b0);
        applyStimulus(1'b0, 1'b0, fifo0[0], fifo1[0], 1'b0);
        #1;
        checkFlag("pre-reset pop_0", pop_0, 1'b1);
        checkFlag("pre-reset valid_out", valid_out, 1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        checkFlag("async pop_0", pop_0, 1'b0);
        checkFlag("async pop_1", pop_1, 1'b0);
        checkFlag("async valid_out", valid_out, 1'b0);
        checkOutput("async data_out", data_out, 8'h00);
        checkOutput("async grant_cnt_0", grant_cnt_0, 8'h00);
        checkOutput("async grant_cnt_1", grant_cnt_1, 8'h00);
        resetModel();
        @(negedge clk);
        reset_L = 1'b1;
        popLog.delete();
        repeat (3) fifoCycle(1'b0);
        exp = '{2, 0, 0};
        checkLog("post-reset grant", exp);

        $display("[TB] randomized traffic");
        applyReset();
        fifo0.delete();
        fifo1.delete();
        for (int i = 0; i < 800; i++) begin
            if (fifo0.size() < 6 && $urandom_range(0, 2) != 0) fifo0.push_back(8'($urandom));
            if (fifo1.size() < 6 && $urandom_range(0, 3) == 0) fifo1.push_back(8'($urandom));
            fifoCycle($urandom_range(0, 4) == 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
